// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for the decode stage.
// Tracks DEPTH downstream writers and picks the youngest in-flight result per source.
module fwd_hazard_unit #(
   parameter int  DATA_W   = 16,
   parameter int  REG_AW   = 3,
   parameter int  DEPTH    = 2,
   parameter int  ZERO_REG = 0,
   localparam int SW       = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    adv,
   input  logic                    flush,
   input  logic                    dec_vld,
   input  logic                    dec_wr_en,
   input  logic [REG_AW-1:0]       dec_wr_reg,
   input  logic                    dec_is_load,
   input  logic [REG_AW-1:0]       dec_rs,
   input  logic [REG_AW-1:0]       dec_rt,
   input  logic [DATA_W-1:0]       rf_a,
   input  logic [DATA_W-1:0]       rf_b,
   input  logic [DEPTH*DATA_W-1:0] stg_data,
   output logic [DATA_W-1:0]       op_a,
   output logic [DATA_W-1:0]       op_b,
   output logic [SW-1:0]           fwd_sel_a,
   output logic [SW-1:0]           fwd_sel_b,
   output logic                    stall,
   output logic [15:0]             stall_cnt,
   output logic                    err
);

   logic [DEPTH:1]    entVld;
   logic [DEPTH:1]    entWr;
   logic [DEPTH:1]    entLd;
   logic [REG_AW-1:0] entReg [1:DEPTH];

   logic [SW-1:0] selA;
   logic [SW-1:0] selB;
   logic          rsLive;
   logic          rtLive;
   logic          hazard;
   logic          illegal;
   logic [15:0]   stallCnt;
   logic          errFlag;

   assign rsLive = (ZERO_REG == 0) || (dec_rs != '0);
   assign rtLive = (ZERO_REG == 0) || (dec_rt != '0);

   // Scan oldest to youngest so the youngest matching stage wins.
   always_comb begin
      selA = '0;
      selB = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (entVld[k] && entWr[k] && (entReg[k] == dec_rs) && rsLive) selA = SW'(k);
         if (entVld[k] && entWr[k] && (entReg[k] == dec_rt) && rtLive) selB = SW'(k);
      end
   end

   always_comb begin
      op_a = rf_a;
      op_b = rf_b;
      for (int k = 1; k <= DEPTH; k++) begin
         if (selA == SW'(k)) op_a = stg_data[(k-1)*DATA_W +: DATA_W];
         if (selB == SW'(k)) op_b = stg_data[(k-1)*DATA_W +: DATA_W];
      end
   end

   // A load result is not available until stage 2, so a stage-1 hit on a load must wait.
   assign hazard  = entVld[1] && entLd[1] && ((selA == SW'(1)) || (selB == SW'(1)));
   assign stall   = dec_vld && hazard && !flush;
   assign illegal = (dec_vld && dec_is_load && !dec_wr_en)
                 || (int'(selA) > DEPTH) || (int'(selB) > DEPTH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entVld   <= '0;
         stallCnt <= '0;
         errFlag  <= 1'b0;
      end else begin
         if (adv) begin
            entVld[1] <= dec_vld && !stall && !flush;
            for (int k = 2; k <= DEPTH; k++) entVld[k] <= entVld[k-1];
         end
         if (stall && (stallCnt != 16'hFFFF)) stallCnt <= stallCnt + 16'd1;
         if (illegal) errFlag <= 1'b1;
      end
   end

   // Entry payload only matters while its valid bit is set.
   always_ff @(posedge clk) begin
      if (adv) begin
         entWr[1]  <= dec_wr_en;
         entLd[1]  <= dec_is_load;
         entReg[1] <= dec_wr_reg;
         for (int k = 2; k <= DEPTH; k++) begin
            entWr[k]  <= entWr[k-1];
            entLd[k]  <= entLd[k-1];
            entReg[k] <= entReg[k-1];
         end
      end
   end

   assign fwd_sel_a = selA;
   assign fwd_sel_b = selB;
   assign stall_cnt = stallCnt;
   assign err       = errFlag;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (ZERO_REG=0 and ZERO_REG=1) share stimulus
// and are compared each cycle against a queue-based model of in-flight instructions.
module tb_fwd_hazard_unit;

   localparam int D = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        adv = 1'b1;
   logic        flush = 1'b0;
   logic        decVld = 1'b0;
   logic        decWr = 1'b0;
   logic        decLd = 1'b0;
   logic [2:0]  decRd = '0;
   logic [2:0]  decRs = '0;
   logic [2:0]  decRt = '0;
   logic [15:0] rfA = '0;
   logic [15:0] rfB = '0;
   logic [31:0] stgData = '0;

   logic [15:0] opA [2];
   logic [15:0] opB [2];
   logic [1:0]  fsA [2];
   logic [1:0]  fsB [2];
   logic        stallO [2];
   logic [15:0] cntO [2];
   logic        errO [2];

   int nTests = 0;
   int nFail  = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit #(.DATA_W(16), .REG_AW(3), .DEPTH(D), .ZERO_REG(0)) u0 (
      .clk(clk), .rst(rst), .adv(adv), .flush(flush), .dec_vld(decVld),
      .dec_wr_en(decWr), .dec_wr_reg(decRd), .dec_is_load(decLd),
      .dec_rs(decRs), .dec_rt(decRt), .rf_a(rfA), .rf_b(rfB), .stg_data(stgData),
      .op_a(opA[0]), .op_b(opB[0]), .fwd_sel_a(fsA[0]), .fwd_sel_b(fsB[0]),
      .stall(stallO[0]), .stall_cnt(cntO[0]), .err(errO[0]));

   fwd_hazard_unit #(.DATA_W(16), .REG_AW(3), .DEPTH(D), .ZERO_REG(1)) u1 (
      .clk(clk), .rst(rst), .adv(adv), .flush(flush), .dec_vld(decVld),
      .dec_wr_en(decWr), .dec_wr_reg(decRd), .dec_is_load(decLd),
      .dec_rs(decRs), .dec_rt(decRt), .rf_a(rfA), .rf_b(rfB), .stg_data(stgData),
      .op_a(opA[1]), .op_b(opB[1]), .fwd_sel_a(fsA[1]), .fwd_sel_b(fsB[1]),
      .stall(stallO[1]), .stall_cnt(cntO[1]), .err(errO[1]));

   // In-flight instruction record; queue index 0 is the youngest (stage 1).
   typedef struct {
      bit vld;
      bit wr;
      bit ld;
      int rd;
   } rec_t;
   typedef rec_t rq_t[$];

   rq_t mq0;
   rq_t mq1;
   int  mCnt [2];
   bit  mErr [2];
   bit  mStall [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic rq_t emptyQ();
      rq_t q;
      rec_t b;
      b.vld = 1'b0; b.wr = 1'b0; b.ld = 1'b0; b.rd = 0;
      for (int i = 0; i < D; i++) q.push_back(b);
      return q;
   endfunction

   function automatic rq_t shiftQ(input rq_t q, input bit st);
      rq_t r;
      rec_t n;
      r = q;
      n.vld = decVld && !st && !flush;
      n.wr  = decWr;
      n.ld  = decLd;
      n.rd  = int'(decRd);
      r.push_front(n);
      void'(r.pop_back());
      return r;
   endfunction

   function automatic int youngest(input rq_t q, input int s, input bit zr);
      for (int i = 0; i < q.size(); i++)
         if (q[i].vld && q[i].wr && q[i].rd == s && !(zr && s == 0)) return i + 1;
      return 0;
   endfunction

   task automatic checkInst(input int n, input rq_t q);
      bit          zr;
      int          sa;
      int          sb;
      bit          st;
      logic [15:0] ea;
      logic [15:0] eb;
      zr = (n == 1);
      sa = youngest(q, int'(decRs), zr);
      sb = youngest(q, int'(decRt), zr);
      st = decVld && !flush && q[0].vld && q[0].ld && (sa == 1 || sb == 1);
      ea = (sa == 0) ? rfA : stgData[(sa-1)*16 +: 16];
      eb = (sb == 0) ? rfB : stgData[(sb-1)*16 +: 16];
      mStall[n] = st;
      chk($sformatf("u%0d.fwd_sel_a", n), 32'(fsA[n]), 32'(sa));
      chk($sformatf("u%0d.fwd_sel_b", n), 32'(fsB[n]), 32'(sb));
      chk($sformatf("u%0d.op_a", n), 32'(opA[n]), 32'(ea));
      chk($sformatf("u%0d.op_b", n), 32'(opB[n]), 32'(eb));
      chk($sformatf("u%0d.stall", n), 32'(stallO[n]), 32'(st));
      chk($sformatf("u%0d.stall_cnt", n), 32'(cntO[n]), 32'(mCnt[n]));
      chk($sformatf("u%0d.err", n), 32'(errO[n]), 32'(mErr[n]));
   endtask

   // Inputs are stable from the falling edge; check mid-low phase, then model the rising edge.
   task automatic cycle();
      #1;
      if (!rst) begin
         mq0 = emptyQ(); mq1 = emptyQ();
         mCnt[0] = 0; mCnt[1] = 0; mErr[0] = 1'b0; mErr[1] = 1'b0;
      end
      checkInst(0, mq0);
      checkInst(1, mq1);
      @(posedge clk);
      if (rst) begin
         for (int n = 0; n < 2; n++) begin
            if (mStall[n] && mCnt[n] < 65535) mCnt[n]++;
            if (decVld && decLd && !decWr) mErr[n] = 1'b1;
         end
         if (adv) begin
            mq0 = shiftQ(mq0, mStall[0]);
            mq1 = shiftQ(mq1, mStall[1]);
         end
      end
      @(negedge clk);
   endtask

   task automatic drv(input bit v, input bit w, input bit l,
                      input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
      decVld = v; decWr = w; decLd = l; decRd = rd; decRs = rs; decRt = rt;
      rfA = 16'($urandom); rfB = 16'($urandom); stgData = $urandom;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      mq0 = emptyQ(); mq1 = emptyQ();
      mCnt[0] = 0; mCnt[1] = 0; mErr[0] = 1'b0; mErr[1] = 1'b0;
      @(negedge clk);

      // Reset behaviour
      rst = 1'b0;
      drv(1, 0, 0, 0, 0, 0);
      rfA = 16'h1234;
      #1;
      chk("rst.op_a", 32'(opA[0]), 32'h1234);
      chk("rst.stall", 32'(stallO[0]), 0);
      chk("rst.err", 32'(errO[0]), 0);
      chk("rst.stall_cnt", 32'(cntO[0]), 0);
      cycle();
      rst = 1'b1;

      // ALU chain
      drv(1, 1, 0, 3, 0, 0); cycle();
      drv(0, 0, 0, 0, 3, 0); stgData[15:0] = 16'hBEEF;
      #1;
      chk("alu.fwd_sel_a1", 32'(fsA[0]), 1);
      chk("alu.op_a", 32'(opA[0]), 32'hBEEF);
      cycle();
      drv(0, 0, 0, 0, 3, 0);
      #1 chk("alu.fwd_sel_a2", 32'(fsA[0]), 2);
      cycle();

      // Youngest writer wins
      drv(1, 1, 0, 5, 0, 0); cycle();
      drv(1, 1, 0, 5, 0, 0); cycle();
      drv(0, 0, 0, 0, 0, 5);
      #1 chk("young.fwd_sel_b", 32'(fsB[0]), 1);
      cycle();

      // Load-use stall
      drv(0, 0, 0, 0, 0, 0); cycle();
      drv(0, 0, 0, 0, 0, 0); cycle();
      drv(1, 1, 1, 2, 0, 0); cycle();
      drv(1, 0, 0, 0, 7, 2);
      #1 chk("ldu.stall1", 32'(stallO[0]), 1);
      cycle();
      drv(1, 0, 0, 0, 7, 2);
      #1;
      chk("ldu.stall0", 32'(stallO[0]), 0);
      chk("ldu.fwd_sel_b", 32'(fsB[0]), 2);
      chk("ldu.stall_cnt", 32'(cntO[0]), 1);
      cycle();

      // Hold for three cycles, then flush a load-use
      drv(1, 1, 1, 4, 0, 0); cycle();
      adv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, 0, 0, 4, 0);
         #1;
         chk("hold.stall", 32'(stallO[0]), 1);
         chk("hold.fwd_sel_a", 32'(fsA[0]), 1);
         cycle();
      end
      adv = 1'b1; flush = 1'b1;
      drv(1, 0, 0, 0, 4, 0);
      #1 chk("flush.stall", 32'(stallO[0]), 0);
      cycle();
      flush = 1'b0;
      drv(0, 0, 0, 0, 4, 0);
      #1;
      chk("flush.fwd_sel_a", 32'(fsA[0]), 2);
      chk("flush.stall_cnt", 32'(cntO[0]), 4);
      cycle();

      // Hardwired zero register and sticky error
      drv(1, 1, 0, 0, 0, 0); cycle();
      drv(0, 0, 0, 0, 0, 0);
      #1;
      chk("zr.u1.fwd_sel_a", 32'(fsA[1]), 0);
      chk("zr.u0.fwd_sel_a", 32'(fsA[0]), 1);
      cycle();
      drv(1, 0, 1, 1, 0, 0); cycle();
      drv(0, 0, 0, 0, 0, 0); cycle();
      drv(0, 0, 0, 0, 0, 0);
      #1 chk("err.sticky", 32'(errO[1]), 1);
      cycle();
      rst = 1'b0;
      drv(0, 0, 0, 0, 0, 0);
      #1 chk("err.cleared", 32'(errO[1]), 0);
      cycle();
      rst = 1'b1;

      // Randomized traffic; a stalled decode instruction is re-presented unchanged
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 199) != 0);
         adv   = ($urandom_range(0, 9) < 8);
         flush = ($urandom_range(0, 9) == 0);
         if (mStall[0] || mStall[1]) begin
            rfA = 16'($urandom); rfB = 16'($urandom); stgData = $urandom;
         end else begin
            drv(($urandom_range(0, 9) < 8), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) < 3), 3'($urandom_range(0, 3)),
                3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)));
            if (decLd && !decWr && $urandom_range(0, 9) != 0) decWr = 1'b1;
         end
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
